// File: rtl/hilo_mult_sequencer.sv
// hilo_mult_sequencer: drives the shared shift-add multiplier for MULT/MULTU
// and owns the HI/LO register pair. Signed operands are reduced to magnitudes
// before launch and the product sign is restored when HI/LO are written.
// Requests arriving while an operation is in flight are held off with stall.
module hilo_mult_sequencer #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 72
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    mult_req,
    input  logic                    mult_signed,
    input  logic [DATA_WIDTH-1:0]   rs_val,
    input  logic [DATA_WIDTH-1:0]   rt_val,
    input  logic                    mfhi_req,
    input  logic                    mflo_req,
    input  logic                    mthi_we,
    input  logic                    mtlo_we,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic                    stall,
    output logic [DATA_WIDTH-1:0]   hilo_rdata,
    output logic                    rdata_valid,
    output logic [DATA_WIDTH-1:0]   hi,
    output logic [DATA_WIDTH-1:0]   lo,
    output logic                    busy,
    output logic                    timeout_err,
    output logic                    mul_start,
    output logic [DATA_WIDTH-1:0]   mul_op1,
    output logic [DATA_WIDTH-1:0]   mul_op2,
    input  logic [2*DATA_WIDTH-1:0] mul_result,
    input  logic                    mul_valid
);

    localparam int DW = DATA_WIDTH;
    localparam int PW = 2 * DATA_WIDTH;
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_WRITE  = 2'd3
    } state_t;

    // Two's complement magnitude; the most negative value maps to 2^(DW-1) unsigned.
    function automatic logic [DW-1:0] magnitude(input logic signed [DW-1:0] v);
        logic [DW-1:0] u;
        u = v;
        return v[DW-1] ? (~u + DW'(1)) : u;
    endfunction

    // Full-width negation used to restore the sign of the product.
    function automatic logic [PW-1:0] negate_prod(input logic [PW-1:0] p);
        return ~p + PW'(1);
    endfunction

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   op1_q, op1_d;
    logic [DW-1:0]   op2_q, op2_d;
    logic            neg_q, neg_d;
    logic [PW-1:0]   prod_q, prod_d;
    logic [DW-1:0]   hi_q, hi_d;
    logic [DW-1:0]   lo_q, lo_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            rvalid_q, rvalid_d;
    logic            terr_q, terr_d;
    logic [PW-1:0]   signed_prod;

    assign signed_prod = neg_q ? negate_prod(prod_q) : prod_q;

    // Next-state, datapath capture and HI/LO update for the sequencer FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        neg_d    = neg_q;
        prod_d   = prod_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        terr_d   = terr_q;

        case (state_q)
            S_IDLE: begin
                // Reads see the value held before any same-cycle MT write.
                if (mfhi_req) begin
                    rdata_d  = hi_q;
                    rvalid_d = 1'b1;
                end else if (mflo_req) begin
                    rdata_d  = lo_q;
                    rvalid_d = 1'b1;
                end
                if (mthi_we) hi_d = wr_data;
                if (mtlo_we) lo_d = wr_data;
                if (mult_req) begin
                    if (mult_signed) begin
                        op1_d = magnitude($signed(rs_val));
                        op2_d = magnitude($signed(rt_val));
                        neg_d = rs_val[DW-1] ^ rt_val[DW-1];
                    end else begin
                        op1_d = rs_val;
                        op2_d = rt_val;
                        neg_d = 1'b0;
                    end
                    cnt_d   = '0;
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A product on the last permitted cycle still wins over the abort.
                if (mul_valid) begin
                    prod_d  = mul_result;
                    state_d = S_WRITE;
                end else if (cnt_q == WAIT_LAST) begin
                    cnt_d   = '0;
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WRITE: begin
                {hi_d, lo_d} = signed_prod;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op1_q    <= '0;
            op2_q    <= '0;
            neg_q    <= 1'b0;
            prod_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op1_q    <= op1_d;
            op2_q    <= op2_d;
            neg_q    <= neg_d;
            prod_q   <= prod_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            terr_q   <= terr_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign mul_start   = (state_q == S_LAUNCH);
    assign mul_op1     = op1_q;
    assign mul_op2     = op2_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign hilo_rdata  = rdata_q;
    assign rdata_valid = rvalid_q;
    assign timeout_err = terr_q;
    assign stall       = busy & (mult_req | mfhi_req | mflo_req | mthi_we | mtlo_we);

endmodule
